// File: rtl/pigasus_match_collector_if.sv
// Match-collector bus: SME match stream in, pkt_end handshake from the core,
// per-packet match list out to the core, plus wrapping statistics.
// slave = collector side, master = SME/core side.
interface pigasus_match_collector_if #(
    parameter int CNT_W = 6
);
    logic [15:0]      match_rule_ID;
    logic             match_valid;
    logic             match_release;
    logic             pkt_end_valid;
    logic             pkt_end_ready;
    logic [15:0]      m_rule_id;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             m_empty_pkt;
    logic             m_overflow;
    logic [CNT_W-1:0] m_count;
    logic [31:0]      stat_pkts;
    logic [31:0]      stat_drops;

    modport slave (
        input  match_rule_ID, match_valid, pkt_end_valid, m_ready,
        output match_release, pkt_end_ready, m_rule_id, m_valid, m_last,
               m_empty_pkt, m_overflow, m_count, stat_pkts, stat_drops
    );

    modport master (
        output match_rule_ID, match_valid, pkt_end_valid, m_ready,
        input  match_release, pkt_end_ready, m_rule_id, m_valid, m_last,
               m_empty_pkt, m_overflow, m_count, stat_pkts, stat_drops
    );
endinterface

// File: rtl/pigasus_match_collector.sv
// Groups SME matches into per-packet lists (dup suppression, per-packet cap).
// Latency: entry visible 1 cycle after push; packet closes FLUSH_CYCLES quiet cycles after pkt_end.
// Backpressure: match_release drops when a needed FIFO push cannot happen; m_ready stalls the FIFO.
// Ports: clk, rst_n (async active-low), bus (slave modport of pigasus_match_collector_if).
module pigasus_match_collector #(
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_MATCHES  = 32,
    parameter int CNT_W        = 6,
    parameter int FLUSH_CYCLES = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pigasus_match_collector_if.slave      bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {COLLECT, FLUSH, CLOSE} state_t;

    typedef struct packed {
        logic [15:0]      id;
        logic             last;
        logic             empty;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    state_t           state_q, state_d;
    logic             active_q;
    logic             hold_v_q;
    logic [15:0]      hold_id_q;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic             ovf_q;
    logic [FW-1:0]    flush_cnt_q;
    logic [31:0]      stat_pkts_q, stat_drops_q;
    entry_t           mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_q, rd_q;

    logic   fifo_empty, fifo_full, pop, can_push;
    logic   is_dup, is_cap, needs_push;
    logic   release_c, accept, pend_rdy_c, push_c, close_done;
    entry_t push_dat;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop        = !fifo_empty && bus.m_ready;
    // A pop on a full FIFO frees the slot in the same cycle.
    assign can_push   = !fifo_full || pop;

    assign is_dup     = hold_v_q && (bus.match_rule_ID == hold_id_q);
    assign is_cap     = (pkt_cnt_q == CNT_W'(MAX_MATCHES));
    assign needs_push = hold_v_q && !is_dup && !is_cap;
    assign accept     = release_c;
    assign close_done = (state_q == CLOSE) && can_push;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (active_q && bus.pkt_end_valid) state_d = FLUSH;
            FLUSH:   if (!accept && flush_cnt_q == '0)  state_d = CLOSE;
            CLOSE:   if (can_push)                      state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Output logic; active_q keeps handshakes low in the first cycle out of reset.
    always_comb begin
        release_c  = 1'b0;
        pend_rdy_c = 1'b0;
        push_c     = 1'b0;
        push_dat   = '0;
        case (state_q)
            COLLECT, FLUSH: begin
                pend_rdy_c = active_q && (state_q == COLLECT);
                release_c  = active_q && bus.match_valid && (can_push || !needs_push);
                if (release_c && needs_push) begin
                    push_c      = 1'b1;
                    push_dat.id = hold_id_q;
                end
            end
            CLOSE: begin
                push_c = can_push;
                if (hold_v_q) begin
                    push_dat.id  = hold_id_q;
                    push_dat.cnt = pkt_cnt_q;
                end else begin
                    push_dat.empty = 1'b1;
                end
                push_dat.last = 1'b1;
                push_dat.ovf  = ovf_q;
            end
            default: ;
        endcase
    end

    // Packet datapath and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= 1'b0;
            hold_v_q     <= 1'b0;
            hold_id_q    <= '0;
            pkt_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            flush_cnt_q  <= '0;
            stat_pkts_q  <= '0;
            stat_drops_q <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
        end else begin
            active_q <= 1'b1;

            if (state_q == COLLECT && pend_rdy_c && bus.pkt_end_valid)
                flush_cnt_q <= FW'(FLUSH_CYCLES - 1);
            else if (state_q == FLUSH) begin
                if (accept)                 flush_cnt_q <= FW'(FLUSH_CYCLES - 1);
                else if (flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - 1'b1;
            end

            if (accept && !is_dup) begin
                if (is_cap) begin
                    ovf_q        <= 1'b1;
                    stat_drops_q <= stat_drops_q + 32'd1;
                end else begin
                    hold_v_q  <= 1'b1;
                    hold_id_q <= bus.match_rule_ID;
                    pkt_cnt_q <= pkt_cnt_q + 1'b1;
                end
            end

            if (close_done) begin
                hold_v_q    <= 1'b0;
                pkt_cnt_q   <= '0;
                ovf_q       <= 1'b0;
                stat_pkts_q <= stat_pkts_q + 32'd1;
            end

            if (push_c) wr_q <= wr_q + 1'b1;
            if (pop)    rd_q <= rd_q + 1'b1;
        end
    end

    // FIFO storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_q[AW-1:0]] <= push_dat;
    end

    entry_t head;
    assign head = mem_q[rd_q[AW-1:0]];

    assign bus.match_release = release_c;
    assign bus.pkt_end_ready = pend_rdy_c;
    assign bus.m_valid       = !fifo_empty;
    assign bus.m_rule_id     = head.id;
    assign bus.m_last        = head.last;
    assign bus.m_empty_pkt   = head.empty;
    assign bus.m_overflow    = head.ovf;
    assign bus.m_count       = head.cnt;
    assign bus.stat_pkts     = stat_pkts_q;
    assign bus.stat_drops    = stat_drops_q;
endmodule

// File: tb/tb_pigasus_match_collector.sv
// Directed bench with scoreboard for pigasus_match_collector.
// Stimulus pushes expected entries; a negedge monitor pops/compares on every handshake.
module tb_pigasus_match_collector;
    localparam int CNT_W = 6;
    localparam int FLUSH_CYCLES = 24;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    // {id, last, empty, ovf, cnt}
    typedef logic [16+3+CNT_W-1:0] exp_t;
    exp_t exp_q[$];

    pigasus_match_collector_if #(.CNT_W(CNT_W)) bus_if ();

    pigasus_match_collector #(
        .FIFO_DEPTH(16), .MAX_MATCHES(32), .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && bus_if.m_valid && bus_if.m_ready) begin
            exp_t got;
            exp_t e;
            got = {bus_if.m_rule_id, bus_if.m_last, bus_if.m_empty_pkt,
                   bus_if.m_overflow, bus_if.m_count};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_entry got id=%0d last=%0d cnt=%0d",
                         bus_if.m_rule_id, bus_if.m_last, bus_if.m_count);
            end else begin
                e = exp_q.pop_front();
                if (got !== e)
                    $display("FAIL entry got={id=%0d last=%0d empty=%0d ovf=%0d cnt=%0d} exp={id=%0d last=%0d empty=%0d ovf=%0d cnt=%0d}",
                             got[24:9], got[8], got[7], got[6], got[5:0],
                             e[24:9], e[8], e[7], e[6], e[5:0]);
                if (got !== e) failures++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic expect_entry(input logic [15:0] id, input logic last, input logic empty,
                                input logic ovf, input logic [CNT_W-1:0] cnt);
        exp_q.push_back({id, last, empty, ovf, cnt});
    endtask

    // Drive one match and hold it until released (bounded).
    task automatic send(input logic [15:0] id);
        int n = 0;
        bus_if.match_valid   = 1'b1;
        bus_if.match_rule_ID = id;
        @(negedge clk);
        while (!bus_if.match_release && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("release_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        bus_if.match_valid = 1'b0;
    endtask

    task automatic pkt_end();
        int n = 0;
        bus_if.pkt_end_valid = 1'b1;
        @(negedge clk);
        while (!bus_if.pkt_end_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pkt_end_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        bus_if.pkt_end_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int idx;
        int stall;

        rst_n                = 1'b0;
        bus_if.match_valid   = 1'b1;
        bus_if.match_rule_ID = 16'd77;
        bus_if.pkt_end_valid = 1'b1;
        bus_if.m_ready       = 1'b0;
        #23;
        chk("rst_match_release", 32'(bus_if.match_release), 32'd0);
        chk("rst_pkt_end_ready", 32'(bus_if.pkt_end_ready), 32'd0);
        chk("rst_m_valid", 32'(bus_if.m_valid), 32'd0);
        chk("rst_stat_pkts", bus_if.stat_pkts, 32'd0);
        chk("rst_stat_drops", bus_if.stat_drops, 32'd0);
        bus_if.match_valid   = 1'b0;
        bus_if.pkt_end_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus_if.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic packet
        expect_entry(16'd5, 0, 0, 0, 0);
        expect_entry(16'd7, 0, 0, 0, 0);
        expect_entry(16'd9, 1, 0, 0, 6'd3);
        send(16'd5); send(16'd7); send(16'd9);
        pkt_end();
        drain();
        chk("stat_pkts_1", bus_if.stat_pkts, 32'd1);

        // Only consecutive duplicates are suppressed
        expect_entry(16'd4, 0, 0, 0, 0);
        expect_entry(16'd6, 0, 0, 0, 0);
        expect_entry(16'd4, 1, 0, 0, 6'd3);
        send(16'd4); send(16'd4); send(16'd4); send(16'd6); send(16'd4);
        pkt_end();
        drain();
        chk("stat_pkts_2", bus_if.stat_pkts, 32'd2);

        // Empty packet and close latency
        expect_entry(16'd0, 1, 1, 0, 6'd0);
        pkt_end();
        n = 0;
        while (!bus_if.m_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("empty_close_latency", 32'(n), 32'(FLUSH_CYCLES + 1));
        drain();

        // Cap: 40 distinct IDs, 32 kept, 8 dropped
        for (int i = 0; i < 31; i++) expect_entry(16'(100 + i), 0, 0, 0, 0);
        expect_entry(16'd131, 1, 0, 1, 6'd32);
        for (int i = 0; i < 40; i++) send(16'(100 + i));
        pkt_end();
        drain();
        chk("stat_drops_cap", bus_if.stat_drops, 32'd8);
        chk("stat_pkts_4", bus_if.stat_pkts, 32'd4);

        // Backpressure: 16 FIFO entries + 1 hold before release drops
        for (int i = 0; i < 19; i++) expect_entry(16'(200 + i), 0, 0, 0, 0);
        expect_entry(16'd219, 1, 0, 0, 6'd20);
        bus_if.m_ready       = 1'b0;
        idx                  = 0;
        stall                = 0;
        n                    = 0;
        bus_if.match_valid   = 1'b1;
        bus_if.match_rule_ID = 16'd200;
        while (idx < 20 && n < 300) begin
            n++;
            @(negedge clk);
            if (bus_if.match_release) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < 20) bus_if.match_rule_ID = 16'(200 + idx);
                else          bus_if.match_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                stall++;
                if (stall == 5) begin
                    chk("accepts_before_stall", 32'(idx), 32'd17);
                    bus_if.m_ready = 1'b1;
                end
            end
        end
        bus_if.match_valid = 1'b0;
        chk("backpressure_all_sent", 32'(idx), 32'd20);
        pkt_end();
        drain();

        // Match at flush_cnt==1 reloads the window and joins the packet
        expect_entry(16'd300, 0, 0, 0, 0);
        expect_entry(16'd301, 1, 0, 0, 6'd2);
        send(16'd300);
        pkt_end();
        repeat (FLUSH_CYCLES - 2) @(posedge clk);
        #1;
        send(16'd301);
        n = 0;
        while (!(bus_if.m_valid && bus_if.m_last) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reload_close_latency", 32'(n), 32'(FLUSH_CYCLES + 1));
        drain();
        chk("stat_pkts_6", bus_if.stat_pkts, 32'd6);

        // Reset mid-FLUSH discards buffered and held entries
        bus_if.m_ready = 1'b0;
        send(16'd400);
        send(16'd401);
        pkt_end();
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_m_valid", 32'(bus_if.m_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("midrst_m_valid", 32'(bus_if.m_valid), 32'd0);
        chk("midrst_stat_pkts", bus_if.stat_pkts, 32'd0);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus_if.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_m_valid", 32'(bus_if.m_valid), 32'd0);

        expect_entry(16'd500, 1, 0, 0, 6'd1);
        send(16'd500);
        pkt_end();
        drain();
        chk("postrst_stat_pkts", bus_if.stat_pkts, 32'd1);
        chk("postrst_stat_drops", bus_if.stat_drops, 32'd0);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pigasus_match_collector.md
Name: pigasus_match_collector

Overview:
- Sits directly downstream of the Pigasus SME wrapper. Drains its arbitrated match stream (match_valid / match_rule_ID / match_release) and groups matches into per-packet records.
- Suppresses back-to-back duplicate rule IDs and caps the number of matches per packet.
- Presents an AXI-Stream-like list to the RISC-V core. Each packet's list is terminated by a last-flagged entry; a packet with no matches gets a single empty record.
- A packet closes after the core signals end of packet and the SME pipeline has been quiet for a programmable flush window.

Parameters:
- FIFO_DEPTH, 16: output FIFO entries; power of 2, minimum 4.
- MAX_MATCHES, 32: maximum stored matches per packet.
- CNT_W, 6: width of m_count; must satisfy 2^CNT_W > MAX_MATCHES.
- FLUSH_CYCLES, 24: quiet cycles after pkt_end before the packet closes; must be ≥ SME pipeline depth.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- match_rule_ID  in  16  rule ID from the SME arbiter.
- match_valid  in  1  match present.
- match_release  out  1  accept/pop of the current match (combinational).
- pkt_end_valid  in  1  core: last data beat of the current packet has been accepted by the SME.
- pkt_end_ready  out  1  pkt_end accepted.
- m_rule_id  out  16  output rule ID; 0 in an empty record.
- m_valid  out  1  output entry valid.
- m_ready  in  1  core pops the entry.
- m_last  out  1  final entry of the packet.
- m_empty_pkt  out  1  packet had no matches (valid only with m_last).
- m_overflow  out  1  matches were dropped at the cap (valid only with m_last).
- m_count  out  CNT_W  number of stored entries for the packet (valid only with m_last).
- stat_pkts  out  32  packets closed; wraps.
- stat_drops  out  32  matches dropped at the cap; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - State = COLLECT; FIFO empty; holding register empty; counters cleared; stat_* = 0.
  - All outputs 0 (match_release=0, pkt_end_ready=0, m_valid=0).
  - A reset mid-packet discards all buffered and held entries; no partial record is emitted.
- Holding register (hold_v, hold_id):
  - Stores the latest accepted match. It is pushed to the FIFO with last=0 when the next distinct match is accepted.
  - When the packet closes, it is pushed with last=1.
- Release rule:
  - match_release = match_valid and state ∈ {COLLECT, FLUSH} and (FIFO not full or a drop/duplicate case that needs no push).
  - accept = match_valid & match_release.
- Classification of an accepted match:
  - Duplicate (hold_v and ID == hold_id): popped and discarded; no count change.
  - Cap reached (pkt_cnt == MAX_MATCHES): popped and discarded; ovf_flag=1; stat_drops+1.
  - Otherwise: push hold if hold_v; hold ← ID; pkt_cnt+1.
- States:
  - COLLECT: pkt_end_ready=1. On pkt_end_valid → FLUSH with flush_cnt ← FLUSH_CYCLES-1. A match accepted in the same cycle belongs to the current packet.
  - FLUSH: pkt_end_ready=0.
    - Any accept reloads flush_cnt ← FLUSH_CYCLES-1; otherwise flush_cnt decrements.
    - flush_cnt==0 with no accept → CLOSE.
  - CLOSE: match_release=0. When the FIFO is not full, push the terminating entry:
    - If hold_v: {hold_id, last=1, empty=0, ovf_flag, pkt_cnt}.
    - Else: {0, last=1, empty=1, ovf_flag, 0}.
    - Then clear hold_v/pkt_cnt/ovf_flag, stat_pkts+1, → COLLECT (1 cycle minimum).
- FIFO:
  - Entry is {id, last, empty, ovf, cnt}; registered output; first-word latency 1 cycle after push.
  - Pop when m_valid & m_ready. Simultaneous push and pop on a full FIFO is allowed (pop frees the slot the same cycle).
  - Pointers wrap modulo FIFO_DEPTH; one extra pointer bit distinguishes full from empty.
- m_count/m_overflow/m_empty_pkt are 0 on non-last entries.
- The SME FIFOs stall (not lost) while match_release is low.

Test Plan:
- Matches 5, 7, 9, then pkt_end, m_ready=1 → entries 5, 7, 9(last, count=3, ovf=0), stat_pkts=1.
- Matches 4, 4, 4, 6, 4 → entries 4, 6, 4(last, count=3); a duplicate is suppressed only when consecutive.
- pkt_end with no matches → single entry id=0, last=1, empty=1, count=0 after FLUSH_CYCLES+1 cycles.
- MAX_MATCHES=32; 40 distinct IDs → 32 entries, last has ovf=1, count=32; stat_drops=8.
- m_ready=0, 20 distinct matches, FIFO_DEPTH=16 → match_release drops low after 17 accepts (16 FIFO + 1 hold); releasing m_ready resumes with no loss or reordering.
- Match arriving at flush_cnt=1 → counter reloads and the match is included; rst_n pulsed mid-FLUSH → m_valid=0 and FIFO empty, and the next packet's record is clean.
